// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
// Holds FSM state encoding, instruction field slices and opcodes.
package alu_issue_ctrl_pkg;

    localparam int IW = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // instr = {op[8:6], rd_a[5:4], rs_a[3:2], rt_a[1:0]}
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 4;
    localparam int RS_HI = 3;
    localparam int RS_LO = 2;
    localparam int RT_HI = 1;
    localparam int RT_LO = 0;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_EQ  = 3'd6;
    localparam logic [2:0] OP_GT  = 3'd7;

endpackage

// File: rtl/alu_regfile_4x4.sv
// Small register file: one synchronous write port, three async reads.
// Ports: i_clk, i_rst, i_we/i_waddr/i_wdata, rs/rt/dbg read address/data.
module alu_regfile_4x4 #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic [DW-1:0]           i_wdata,
    input  logic [$clog2(NREG)-1:0] i_rs_addr,
    output logic [DW-1:0]           o_rs_data,
    input  logic [$clog2(NREG)-1:0] i_rt_addr,
    output logic [DW-1:0]           o_rt_data,
    input  logic [$clog2(NREG)-1:0] i_dbg_addr,
    output logic [DW-1:0]           o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rs_data  = r_mem[i_rs_addr];
    assign o_rt_data  = r_mem[i_rt_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues 9-bit instructions to a combinational 4-bit ALU and writes back.
// Ports: clk/rst, instr valid/ready/instr, host write, debug read,
// ALU rs/rt/sel out and rd in, done pulse and held result.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [IW-1:0]           instr,
    output logic                    instr_ready,
    input  logic                    host_we,
    input  logic [$clog2(NREG)-1:0] host_addr,
    input  logic [DW-1:0]           host_data,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]           dbg_data,
    output logic [DW-1:0]           alu_rs,
    output logic [DW-1:0]           alu_rt,
    output logic [2:0]              alu_sel,
    input  logic [DW-1:0]           alu_rd,
    output logic                    done,
    output logic [DW-1:0]           result
);

    localparam int AW = $clog2(NREG);

    state_t        r_state;
    logic [IW-1:0] r_instr;
    logic [DW-1:0] r_res;
    logic [DW-1:0] r_alu_rs;
    logic [DW-1:0] r_alu_rt;
    logic [2:0]    r_alu_sel;
    logic          r_done;
    logic [DW-1:0] r_result;

    logic [AW-1:0] w_rd_a;
    logic [AW-1:0] w_rs_a;
    logic [AW-1:0] w_rt_a;
    logic [DW-1:0] w_rs_d;
    logic [DW-1:0] w_rt_d;
    logic          w_idle;
    logic          w_wb;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    assign w_rd_a = r_instr[RD_HI:RD_LO];
    assign w_rs_a = r_instr[RS_HI:RS_LO];
    assign w_rt_a = r_instr[RT_HI:RT_LO];

    assign w_idle = (r_state == S_IDLE);
    assign w_wb   = (r_state == S_WB);

    // Host writes only land in IDLE; writeback owns the port in WB.
    assign w_we    = w_wb | (w_idle & host_we);
    assign w_waddr = w_wb ? w_rd_a : host_addr;
    assign w_wdata = w_wb ? r_res  : host_data;

    assign instr_ready = w_idle & ~host_we;

    alu_regfile_4x4 #(
        .NREG (NREG),
        .DW   (DW)
    ) u_rf (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_rs_addr  (w_rs_a),
        .o_rs_data  (w_rs_d),
        .i_rt_addr  (w_rt_a),
        .o_rt_data  (w_rt_d),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_res     <= '0;
            r_alu_rs  <= '0;
            r_alu_rt  <= '0;
            r_alu_sel <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_instr <= instr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_alu_rs  <= w_rs_d;
                    r_alu_rt  <= w_rt_d;
                    r_alu_sel <= r_instr[OP_HI:OP_LO];
                    r_state   <= S_CAPT;
                end
                S_CAPT: begin
                    r_res   <= alu_rd;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_result <= r_res;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_rs  = r_alu_rs;
    assign alu_rt  = r_alu_rt;
    assign alu_sel = r_alu_sel;
    assign done    = r_done;
    assign result  = r_result;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a combinational ALU model.
// Each task drives one scenario and checks hand-computed values inline.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       host_we;
    logic [1:0] host_addr;
    logic [3:0] host_data;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic [3:0] alu_rs;
    logic [3:0] alu_rt;
    logic [2:0] alu_sel;
    logic [3:0] alu_rd;
    logic       done;
    logic [3:0] result;

    int checks;
    int failures;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_rs      (alu_rs),
        .alu_rt      (alu_rt),
        .alu_sel     (alu_sel),
        .alu_rd      (alu_rd),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_rd = 4'h0;
        case (alu_sel)
            3'd0: alu_rd = alu_rs + alu_rt;
            3'd1: alu_rd = alu_rs - alu_rt;
            3'd2: alu_rd = alu_rs & alu_rt;
            3'd3: alu_rd = alu_rs | alu_rt;
            3'd4: alu_rd = {alu_rs[2:0], alu_rs[3]};
            3'd5: alu_rd = {alu_rt[3], alu_rt[3:1]};
            3'd6: alu_rd = {3'b111, alu_rs == alu_rt};
            3'd7: alu_rd = {3'b101, alu_rs > alu_rt};
            default: alu_rd = 4'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [3:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_data = d;
        tick();
        host_we = 1'b0;
    endtask

    // Offer one instruction in IDLE and count cycles from accept to done.
    task automatic run_instr(input logic [8:0] ins, output int lat);
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%0b exp=0", done);
        end
        checks++;
        if (result !== 4'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if ({alu_sel, alu_rs, alu_rt} !== 11'h0) begin
            failures++;
            $display("FAIL reset_alu got=%h exp=0", {alu_sel, alu_rs, alu_rt});
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", instr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'h0) begin
                failures++;
                $display("FAIL reset_rf%0d got=%h exp=0", i, dbg_data);
            end
        end
    endtask

    task automatic test_add();
        int lat;
        host_write(2'd0, 4'h3);
        host_write(2'd1, 4'h5);
        run_instr({3'd0, 2'd2, 2'd0, 2'd1}, lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=3", lat);
        end
        checks++;
        if ({alu_sel, alu_rs, alu_rt} !== {3'd0, 4'h3, 4'h5}) begin
            failures++;
            $display("FAIL add_operands got=%h exp=%h",
                     {alu_sel, alu_rs, alu_rt}, {3'd0, 4'h3, 4'h5});
        end
        checks++;
        if (result !== 4'h8) begin
            failures++;
            $display("FAIL add_result got=%h exp=8", result);
        end
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'h8) begin
            failures++;
            $display("FAIL add_r2 got=%h exp=8", dbg_data);
        end
    endtask

    task automatic test_sub_shift();
        int lat;
        host_write(2'd0, 4'h3);
        host_write(2'd1, 4'h5);
        run_instr({3'd1, 2'd3, 2'd0, 2'd1}, lat);
        dbg_addr = 2'd3;
        #1;
        checks++;
        if (result !== 4'hE || dbg_data !== 4'hE) begin
            failures++;
            $display("FAIL sub_wrap got=%h/%h exp=e", result, dbg_data);
        end
        run_instr({3'd5, 2'd3, 2'd3, 2'd3}, lat);
        #1;
        checks++;
        if (result !== 4'hF || dbg_data !== 4'hF) begin
            failures++;
            $display("FAIL asr got=%h/%h exp=f", result, dbg_data);
        end
    endtask

    task automatic test_cmp_alias();
        int lat;
        host_write(2'd0, 4'h9);
        host_write(2'd1, 4'h9);
        run_instr({3'd6, 2'd0, 2'd0, 2'd1}, lat);
        dbg_addr = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 4'hF) begin
            failures++;
            $display("FAIL cmp_eq got=%h exp=f", dbg_data);
        end
        run_instr({3'd7, 2'd1, 2'd0, 2'd1}, lat);
        dbg_addr = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'hB || result !== 4'hB) begin
            failures++;
            $display("FAIL cmp_gt got=%h/%h exp=b", dbg_data, result);
        end
    endtask

    task automatic test_rotate();
        int lat;
        host_write(2'd2, 4'h9);
        run_instr({3'd4, 2'd1, 2'd2, 2'd0}, lat);
        dbg_addr = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'h3 || result !== 4'h3) begin
            failures++;
            $display("FAIL rotate got=%h/%h exp=3", dbg_data, result);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rot_done_hi got=%0b exp=1", done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rot_done_width got=%0b exp=0", done);
        end
    endtask

    task automatic test_handshake();
        int acc[2];
        int n;
        int lat;
        host_write(2'd0, 4'h1);
        host_write(2'd1, 4'h2);
        n = 0;
        acc[0] = 0;
        acc[1] = 0;
        instr       = {3'd0, 2'd2, 2'd0, 2'd1};
        instr_valid = 1'b1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (instr_ready) begin
                acc[n] = c;
                n++;
            end
            tick();
            if (n == 1) instr = {3'd1, 2'd3, 2'd1, 2'd0};
        end
        instr_valid = 1'b0;
        checks++;
        if (n !== 2 || acc[1] - acc[0] !== 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d/%0d exp=2/4",
                     n, acc[1] - acc[0]);
        end
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'h3) begin
            failures++;
            $display("FAIL b2b_r2 got=%h exp=3", dbg_data);
        end
        dbg_addr = 2'd3;
        #1;
        checks++;
        if (dbg_data !== 4'h1) begin
            failures++;
            $display("FAIL b2b_r3 got=%h exp=1", dbg_data);
        end
        // Host write during ISSUE must be dropped.
        instr       = {3'd3, 2'd2, 2'd0, 2'd1};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        host_we   = 1'b1;
        host_addr = 2'd0;
        host_data = 4'hF;
        tick();
        host_we = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        dbg_addr = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 4'h1) begin
            failures++;
            $display("FAIL busy_drop got=%h exp=1", dbg_data);
        end
        // Host write and instruction together: write wins.
        tick();
        host_we     = 1'b1;
        host_addr   = 2'd1;
        host_data   = 4'h7;
        instr       = {3'd0, 2'd1, 2'd1, 2'd1};
        instr_valid = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            failures++;
            $display("FAIL host_prio_ready got=%0b exp=0", instr_ready);
        end
        tick();
        host_we     = 1'b0;
        instr_valid = 1'b0;
        dbg_addr    = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'h7 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL host_prio got=%h/%0b exp=7/1",
                     dbg_data, instr_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        host_write(2'd0, 4'h3);
        host_write(2'd1, 4'h5);
        instr       = {3'd0, 2'd2, 2'd0, 2'd1};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%0b exp=1", instr_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rstmid_done got=%0d exp=0", seen);
        end
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'h0 || result !== 4'h0) begin
            failures++;
            $display("FAIL rstmid_rd got=%h/%h exp=0", dbg_data, result);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_data   = '0;
        dbg_addr    = '0;
        test_reset();
        test_add();
        test_sub_shift();
        test_cmp_alias();
        test_rotate();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
